gpr_scoreboard: RTL and testbench
=================================

# gpr_scoreboard

Read-side hazard tracker for the pipelined CPU's general-purpose register file. Every instruction leaving decode is checked against a per-register pending-write count and held if a source operand is still in flight. Issued writes increment the target's count and register-file writebacks decrement it. Register-file reads then always return committed data without a forwarding network.

## Interface
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1
- STALL_W, 16, width of the stall-cycle statistics counter
- Clk  in  1  clock, all state updates on rising edge
- Rst  in  1  reset, asynchronous, active-high; clock Clk
- Flush  in  1  synchronous clear of all pending counts (pipeline flush)
- IssueValid  in  1  decode presents an instruction
- UseRs  in  1  instruction reads IssueRs
- IssueRs  in  5  first source register index
- UseRt  in  1  instruction reads IssueRt
- IssueRt  in  5  second source register index
- IssueWe  in  1  instruction will write IssueDst
- IssueDst  in  5  destination register index
- IssueReady  out  1  instruction may issue this cycle
- WbValid  in  1  register-file write occurring this cycle (same qualifier as the file's write enable)
- WbDst  in  5  register-file write address
- Busy  out  32  bit i = 1 when register i has a nonzero pending count
- Err  out  1  sticky: writeback to a register with count 0
- StallCnt  out  STALL_W  cycles spent with IssueValid=1 and IssueReady=0

## Operation
- State: cnt[1..31], each CNT_W bits. $0 has no counter. Busy[0] is constant 0, and index 0 is never a hazard or a target.
- Hazard terms, computed only from registered counts:
  - hzRs = UseRs & IssueRs!=0 & cnt[IssueRs]!=0
  - hzRt = UseRt & IssueRt!=0 & cnt[IssueRt]!=0
  - hzFull = IssueWe & IssueDst!=0 & cnt[IssueDst]==max
- IssueReady = !Flush & !hzRs & !hzRt & !hzFull. It is combinational and independent of IssueValid.
- Accept = IssueValid & IssueReady.
- Per register r, each edge, in priority order:
  - Flush: cnt[r] <= 0.
  - Otherwise, inc = Accept & IssueWe & IssueDst==r; dec = WbValid & WbDst==r & cnt[r]!=0.
  - inc & dec: unchanged. inc only: +1. dec only: -1.
- Same-cycle writeback does not release a stall. The source becomes ready the cycle after the writeback edge, which matches the register file being written on that edge.
- An instruction with IssueDst equal to its own source stalls only when that source is pending; self-dependency itself adds no extra stall.
- Err: set when WbValid & WbDst!=0 & cnt[WbDst]==0 & !Flush. It clears only on Rst.
- StallCnt: increments when IssueValid & !IssueReady, saturates at all-ones, and clears only on Rst. Flush cycles with IssueValid=1 are counted.

## Timing
- Reset values: all cnt = 0, Busy = 0, Err = 0, StallCnt = 0. IssueReady = 1 whenever Flush = 0.
- Rst asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Issue-to-busy latency: Busy[d] rises on the edge that accepts the write.
- Writeback-to-ready latency: the dependent instruction's IssueReady rises combinationally in the cycle after the WbValid edge. This gives a zero-bubble handoff relative to the register-file write.
- Flush and a writeback in the same cycle: the count goes to 0 and Err does not set. A writeback arriving after a flush to a now-zero register does set Err.
- Outputs Busy and Err are registered. StallCnt is registered. IssueReady is combinational from registers and inputs.

## Test plan
- Reset release: Rst pulse mid-run with cnt[5]=2 -> Busy=0, Err=0, StallCnt=0, and IssueReady=1 with UseRs=1, IssueRs=5.
- RAW stall: issue with IssueWe=1, IssueDst=8; next cycle IssueValid=1, UseRs=1, IssueRs=8 -> IssueReady=0. Assert WbValid with WbDst=8 -> IssueReady still 0 that cycle and 1 the following cycle. StallCnt = number of held cycles.
- $0 immunity: IssueWe=1, IssueDst=0 accepted -> Busy=0. Then UseRt=1, IssueRt=0 -> IssueReady=1.
- Saturation: three accepted writes to $9 with CNT_W=2 -> Busy[9]=1. A fourth with IssueWe=1, IssueDst=9 -> IssueReady=0. One writeback to $9 -> ready next cycle.
- Simultaneous inc/dec: cnt[10]=1, same cycle accept IssueDst=10 and WbValid with WbDst=10 -> cnt[10] stays 1 and Busy[10]=1. Two more writebacks to $10 -> Busy[10]=0, then Err=1.
- Flush: cnt[3]=2, cnt[4]=1, Flush=1 with IssueValid=1 -> IssueReady=0, StallCnt+1, next cycle Busy=0. A subsequent WbValid with WbDst=3 -> Err=1.

Source files
------------

// File: rtl/gpr_scoreboard_if.sv
// Issue/writeback bundle between decode, the register file and the GPR scoreboard.
// The master side is the pipeline that drives requests; the slave side is the scoreboard.
interface gpr_scoreboard_if #(
  parameter int STALL_W = 16
);
  logic               Flush;
  logic               IssueValid;
  logic               UseRs;
  logic [4:0]         IssueRs;
  logic               UseRt;
  logic [4:0]         IssueRt;
  logic               IssueWe;
  logic [4:0]         IssueDst;
  logic               IssueReady;
  logic               WbValid;
  logic [4:0]         WbDst;
  logic [31:0]        Busy;
  logic               Err;
  logic [STALL_W-1:0] StallCnt;

  modport master (
    output Flush, IssueValid, UseRs, IssueRs, UseRt, IssueRt, IssueWe, IssueDst,
    output WbValid, WbDst,
    input  IssueReady, Busy, Err, StallCnt
  );

  modport slave (
    input  Flush, IssueValid, UseRs, IssueRs, UseRt, IssueRt, IssueWe, IssueDst,
    input  WbValid, WbDst,
    output IssueReady, Busy, Err, StallCnt
  );
endinterface

// File: rtl/gpr_scoreboard.sv
// Per-register pending-write counters that hold decode while a source operand is in flight.
// Hazards are judged from registered counts only, so a writeback releases its reader one cycle later.
module gpr_scoreboard #(
  parameter int CNT_W   = 2,
  parameter int STALL_W = 16
) (
  input  logic           Clk,
  input  logic           Rst,
  gpr_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]   cnt [32];
  logic [31:0]        inc;
  logic [31:0]        dec;
  logic [31:0]        busy;
  logic               hz_rs;
  logic               hz_rt;
  logic               hz_full;
  logic               ready;
  logic               accept;
  logic               err_q;
  logic [STALL_W-1:0] stall_q;

  // Entry 0 is reset to zero and never written, so $0 is never a hazard or a target.
  assign hz_rs   = sb.UseRs & (sb.IssueRs != 5'd0) & (cnt[sb.IssueRs] != '0);
  assign hz_rt   = sb.UseRt & (sb.IssueRt != 5'd0) & (cnt[sb.IssueRt] != '0);
  assign hz_full = sb.IssueWe & (sb.IssueDst != 5'd0) & (cnt[sb.IssueDst] == CNT_MAX);
  assign ready   = ~sb.Flush & ~hz_rs & ~hz_rt & ~hz_full;
  assign accept  = sb.IssueValid & ready;

  always_comb begin
    inc  = '0;
    dec  = '0;
    busy = '0;
    for (int r = 1; r < 32; r++) begin
      inc[r]  = accept & sb.IssueWe & (sb.IssueDst == 5'(r));
      dec[r]  = sb.WbValid & (sb.WbDst == 5'(r)) & (cnt[r] != '0);
      busy[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else if (sb.Flush) begin
      for (int r = 0; r < 32; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (inc[r] & ~dec[r])
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec[r] & ~inc[r])
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  // A writeback to an idle register means the pipeline lost track of a write.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      err_q <= 1'b0;
    else if (sb.WbValid & (sb.WbDst != 5'd0) & (cnt[sb.WbDst] == '0) & ~sb.Flush)
      err_q <= 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      stall_q <= '0;
    else if (sb.IssueValid & ~ready & (stall_q != '1))
      stall_q <= stall_q + STALL_W'(1);
  end

  assign sb.IssueReady = ready;
  assign sb.Busy       = busy;
  assign sb.Err        = err_q;
  assign sb.StallCnt   = stall_q;

endmodule

// File: tb/tb_gpr_scoreboard.sv
// Directed bench for gpr_scoreboard: reset, RAW stall, $0, saturation, inc/dec overlap, flush.
module tb_gpr_scoreboard;

  logic Clk;
  logic Rst;
  int   n_checks = 0;
  int   n_err    = 0;

  gpr_scoreboard_if #(.STALL_W(16)) sb ();

  gpr_scoreboard #(.CNT_W(2), .STALL_W(16)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .sb  (sb.slave)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.Flush      = 1'b0;
    sb.IssueValid = 1'b0;
    sb.UseRs      = 1'b0;
    sb.IssueRs    = 5'd0;
    sb.UseRt      = 1'b0;
    sb.IssueRt    = 5'd0;
    sb.IssueWe    = 1'b0;
    sb.IssueDst   = 5'd0;
    sb.WbValid    = 1'b0;
    sb.WbDst      = 5'd0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled one more unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue_wr(input logic [4:0] d);
    idle();
    sb.IssueValid = 1'b1;
    sb.IssueWe    = 1'b1;
    sb.IssueDst   = d;
    tick();
  endtask

  task automatic wb(input logic [4:0] d);
    idle();
    sb.WbValid = 1'b1;
    sb.WbDst   = d;
    tick();
  endtask

  initial begin
    Rst = 1'b1;
    idle();
    #12 Rst = 1'b0;
    #1;
    chk("reset_busy", sb.Busy, 32'h0);
    chk("reset_err", {31'd0, sb.Err}, 32'h0);
    chk("reset_stall", {16'd0, sb.StallCnt}, 32'h0);
    chk("reset_ready", {31'd0, sb.IssueReady}, 32'h1);

    // Reset release mid-run with cnt[5]=2 and one stall counted
    tick();
    issue_wr(5'd5);
    chk("r5_busy1", sb.Busy, 32'h0000_0020);
    issue_wr(5'd5);
    idle();
    sb.IssueValid = 1'b1;
    sb.UseRs      = 1'b1;
    sb.IssueRs    = 5'd5;
    #1 chk("r5_stall_ready", {31'd0, sb.IssueReady}, 32'h0);
    tick();
    chk("r5_stallcnt", {16'd0, sb.StallCnt}, 32'h1);
    #2 Rst = 1'b1;
    #1;
    chk("async_rst_busy", sb.Busy, 32'h0);
    chk("async_rst_stall", {16'd0, sb.StallCnt}, 32'h0);
    chk("async_rst_err", {31'd0, sb.Err}, 32'h0);
    Rst = 1'b0;
    #1 chk("async_rst_ready_rs5", {31'd0, sb.IssueReady}, 32'h1);
    tick();
    idle();

    // RAW stall on $8, released the cycle after the writeback edge
    issue_wr(5'd8);
    chk("raw_busy8", sb.Busy, 32'h0000_0100);
    idle();
    sb.IssueValid = 1'b1;
    sb.UseRs      = 1'b1;
    sb.IssueRs    = 5'd8;
    #1 chk("raw_hold", {31'd0, sb.IssueReady}, 32'h0);
    tick();
    tick();
    sb.WbValid = 1'b1;
    sb.WbDst   = 5'd8;
    #1 chk("raw_hold_during_wb", {31'd0, sb.IssueReady}, 32'h0);
    tick();
    sb.WbValid = 1'b0;
    #1;
    chk("raw_release", {31'd0, sb.IssueReady}, 32'h1);
    chk("raw_stallcnt", {16'd0, sb.StallCnt}, 32'h3);
    chk("raw_busy_clear", sb.Busy, 32'h0);
    tick();
    idle();

    // $0 is never a target nor a hazard
    issue_wr(5'd0);
    chk("r0_busy", sb.Busy, 32'h0);
    idle();
    sb.IssueValid = 1'b1;
    sb.UseRt      = 1'b1;
    sb.IssueRt    = 5'd0;
    #1 chk("r0_ready", {31'd0, sb.IssueReady}, 32'h1);
    tick();
    chk("r0_stallcnt", {16'd0, sb.StallCnt}, 32'h3);

    // Saturation of $9 at 3 in-flight writes
    issue_wr(5'd9);
    issue_wr(5'd9);
    issue_wr(5'd9);
    chk("sat_busy9", sb.Busy, 32'h0000_0200);
    idle();
    sb.IssueValid = 1'b1;
    sb.IssueWe    = 1'b1;
    sb.IssueDst   = 5'd9;
    #1 chk("sat_full_hold", {31'd0, sb.IssueReady}, 32'h0);
    tick();
    chk("sat_stallcnt", {16'd0, sb.StallCnt}, 32'h4);
    wb(5'd9);
    idle();
    sb.IssueWe  = 1'b1;
    sb.IssueDst = 5'd9;
    #1 chk("sat_release", {31'd0, sb.IssueReady}, 32'h1);
    idle();

    // Simultaneous inc/dec on $10 keeps the count at 1
    issue_wr(5'd10);
    idle();
    sb.IssueValid = 1'b1;
    sb.IssueWe    = 1'b1;
    sb.IssueDst   = 5'd10;
    sb.WbValid    = 1'b1;
    sb.WbDst      = 5'd10;
    #1 chk("incdec_ready", {31'd0, sb.IssueReady}, 32'h1);
    tick();
    chk("incdec_busy", sb.Busy, 32'h0000_0600);
    wb(5'd10);
    chk("incdec_busy_clear", sb.Busy, 32'h0000_0200);
    chk("incdec_no_err", {31'd0, sb.Err}, 32'h0);
    wb(5'd10);
    chk("incdec_err", {31'd0, sb.Err}, 32'h1);
    idle();

    // Err is sticky until Rst
    tick();
    chk("err_sticky", {31'd0, sb.Err}, 32'h1);
    #2 Rst = 1'b1;
    #1 Rst = 1'b0;
    chk("err_cleared_by_rst", {31'd0, sb.Err}, 32'h0);
    tick();

    // Flush with cnt[3]=2, cnt[4]=1, plus a writeback to idle $7 in the flush cycle
    issue_wr(5'd3);
    issue_wr(5'd3);
    issue_wr(5'd4);
    chk("flush_pre_busy", sb.Busy, 32'h0000_0018);
    idle();
    sb.Flush      = 1'b1;
    sb.IssueValid = 1'b1;
    sb.WbValid    = 1'b1;
    sb.WbDst      = 5'd7;
    #1 chk("flush_ready", {31'd0, sb.IssueReady}, 32'h0);
    tick();
    idle();
    #1;
    chk("flush_busy", sb.Busy, 32'h0);
    chk("flush_stallcnt", {16'd0, sb.StallCnt}, 32'h1);
    chk("flush_wb_no_err", {31'd0, sb.Err}, 32'h0);
    wb(5'd3);
    chk("post_flush_wb_err", {31'd0, sb.Err}, 32'h1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
